ysyx_22041207_muldiv_ctrl: RTL

//  Sequencer between the EXU/ALU and the shared iterative multiplier and divider.
//  - Accepts one M-extension op at a time and stalls the pipeline while it runs.
//  - Drives the valid/ready/flush handshakes of both units.
//  - Resolves divide-by-zero and signed-overflow corner cases without issuing to the divider.
//  - Applies RV64 word (*W) operand/result extension and returns one registered result.

---
 rtl/ysyx_22041207_muldiv_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041207_muldiv_ctrl.sv
// Sequencer between the EXU and the shared iterative multiplier/divider: one M-extension op
// at a time, divider corner cases resolved locally, *W extension. Optional result cache: MULDIV_CACHE_EN.
module ysyx_22041207_muldiv_ctrl #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            mul_valid,
  output logic [1:0]      mul_sign,
  output logic            mul_flush,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic            mul_ready,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  output logic            div_valid,
  output logic            div_signed,
  output logic            div_flush,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic            div_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [1:0]      msign_q, msign_d;
  logic            dsigned_q, dsigned_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            resp_q, resp_d;

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic zext);
    if (zext) word_ext = {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
    else      word_ext = {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

  // Request decode: extended operands and divider corner cases.
  logic            req_is_div;
  logic            req_div_sgn;
  logic            req_word_eff;
  logic            req_zext;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] div_min;
  logic            req_b_zero;
  logic            req_ovf;
  logic            req_corner;
  logic [XLEN-1:0] corner_raw;
  logic [XLEN-1:0] corner_res;
  logic [1:0]      req_msign;

  assign req_is_div   = req_op[2];
  assign req_div_sgn  = req_op[2] & ~req_op[0];
  // High-half multiplies have no word form, so the word bit is dropped for them.
  assign req_word_eff = req_word & ((req_op == OP_MUL) | req_op[2]);
  assign req_zext     = req_op[2] & req_op[0];
  assign a_ext        = req_word_eff ? word_ext(req_a, req_zext) : req_a;
  assign b_ext        = req_word_eff ? word_ext(req_b, req_zext) : req_b;
  assign div_min      = req_word_eff ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                                     : {1'b1, {(XLEN-1){1'b0}}};
  assign req_b_zero   = (b_ext == {XLEN{1'b0}});
  assign req_ovf      = req_div_sgn & (a_ext == div_min) & (b_ext == {XLEN{1'b1}});
  assign req_corner   = req_is_div & (req_b_zero | req_ovf);

  always_comb begin
    corner_raw = {XLEN{1'b0}};
    if (req_b_zero) corner_raw = req_op[1] ? a_ext : {XLEN{1'b1}};
    else            corner_raw = req_op[1] ? {XLEN{1'b0}} : a_ext;
    corner_res = req_word_eff ? word_ext(corner_raw, 1'b0) : corner_raw;
  end

  always_comb begin
    req_msign = 2'b00;
    case (req_op)
      OP_MUL, OP_MULH: req_msign = 2'b11;
      OP_MULHSU:       req_msign = 2'b10;
      default:         req_msign = 2'b00;
    endcase
  end

  // Active-unit view of the latched op.
  logic            unit_is_div;
  logic            unit_ready;
  logic            unit_out_valid;
  logic [XLEN-1:0] unit_raw;
  logic [XLEN-1:0] unit_res;

  assign unit_is_div    = op_q[2];
  assign unit_ready     = unit_is_div ? div_ready : mul_ready;
  assign unit_out_valid = unit_is_div ? div_out_valid : mul_out_valid;

  always_comb begin
    unit_raw = {XLEN{1'b0}};
    if (unit_is_div) unit_raw = op_q[1] ? div_rem : div_quot;
    else             unit_raw = (op_q == OP_MUL) ? mul_lo : mul_hi;
    unit_res = word_q ? word_ext(unit_raw, 1'b0) : unit_raw;
  end

  logic            cache_hit;
  logic [XLEN-1:0] cache_res;

`ifdef MULDIV_CACHE_EN
  logic            cv_q;
  logic [2:0]      cop_q;
  logic            cword_q;
  logic [XLEN-1:0] ca_q;
  logic [XLEN-1:0] cb_q;
  logic [XLEN-1:0] cres_q;

  assign cache_hit = cv_q & (cop_q == req_op) & (cword_q == req_word_eff) &
                     (ca_q == a_ext) & (cb_q == b_ext);
  assign cache_res = cres_q;

  // Entry is written whenever a response is presented; flush leaves it intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      cv_q    <= 1'b0;
      cop_q   <= 3'd0;
      cword_q <= 1'b0;
      ca_q    <= {XLEN{1'b0}};
      cb_q    <= {XLEN{1'b0}};
      cres_q  <= {XLEN{1'b0}};
    end else if (state_q == S_DONE) begin
      cv_q    <= 1'b1;
      cop_q   <= op_q;
      cword_q <= word_q;
      ca_q    <= a_q;
      cb_q    <= b_q;
      cres_q  <= res_q;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = {XLEN{1'b0}};
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    a_d       = a_q;
    b_d       = b_q;
    msign_d   = msign_q;
    dsigned_d = dsigned_q;
    res_d     = res_q;
    resp_d    = 1'b0;
    mul_valid = 1'b0;
    div_valid = 1'b0;
    mul_flush = 1'b0;
    div_flush = 1'b0;
    if (flush) begin
      // A result arriving alongside the flush is dropped with the op.
      state_d = S_IDLE;
      if ((state_q == S_ISSUE) || (state_q == S_BUSY)) begin
        mul_flush = ~unit_is_div;
        div_flush = unit_is_div;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_d      = req_op;
            word_d    = req_word_eff;
            a_d       = a_ext;
            b_d       = b_ext;
            msign_d   = req_is_div ? 2'b00 : req_msign;
            dsigned_d = req_div_sgn;
            if (req_corner) begin
              res_d   = corner_res;
              resp_d  = 1'b1;
              state_d = S_DONE;
            end else if (cache_hit) begin
              res_d   = cache_res;
              resp_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (unit_ready) begin
            mul_valid = ~unit_is_div;
            div_valid = unit_is_div;
            state_d   = S_BUSY;
          end
        end
        S_BUSY: begin
          if (unit_out_valid) begin
            res_d   = unit_res;
            resp_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      word_q    <= 1'b0;
      a_q       <= {XLEN{1'b0}};
      b_q       <= {XLEN{1'b0}};
      msign_q   <= 2'b00;
      dsigned_q <= 1'b0;
      res_q     <= {XLEN{1'b0}};
      resp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      word_q    <= word_d;
      a_q       <= a_d;
      b_q       <= b_d;
      msign_q   <= msign_d;
      dsigned_q <= dsigned_d;
      res_q     <= res_d;
      resp_q    <= resp_d;
    end
  end

  assign stall      = req_valid & ~resp_q;
  assign resp_valid = resp_q;
  assign resp_data  = res_q;
  assign mul_sign   = msign_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign div_signed = dsigned_q;
  assign div_a      = a_q;
  assign div_b      = b_q;

endmodule
